// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the unified-memory arbiter.
// Latency : n/a (types only).
// Backpressure: n/a.
// Contents: arb_state_t FSM encoding, owner encodings, counter width.
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN (round-robin ties).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose : combinational winner select between CPU and DBG requests.
// Latency : zero cycles (pure combinational).
// Backpressure: none; caller only consumes the grant while idle.
// Ports   : cpu_req, dbg_req, last (previous winner) -> grant_valid, grant_owner.
// Macro   : MEM_ARB_RR_EN defined = round-robin on ties (grant the port that
//           is not 'last'); undefined = fixed priority, DBG wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last,
  output logic grant_valid,
  output logic grant_owner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      // Tie: hand the memory to whichever port did not win last time.
      grant_owner = ~last;
    end else if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`else
  // Fixed priority has no fairness state; the input is carried for a
  // uniform port list only.
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant_owner = OWN_CPU;
    // DBG wins any tie, so a busy loader can starve the CPU by design.
    if (dbg_req) begin
      grant_owner = OWN_DBG;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one unified I/D memory between the CPU and a debug/loader
//           port, serialising each request into one fixed-latency access.
// Latency : request seen in IDLE at cycle 0 -> mem access cycles 1..MEM_LAT,
//           ack pulse in cycle MEM_LAT+1, re-arbitration in cycle MEM_LAT+2.
// Backpressure: requesters hold req until ack; cpu_stall = cpu_req & ~cpu_ack.
// Ports   : clk/rst (sync, active high); cpu_* and dbg_* request ports
//           (req/we/addr/wdata in, ack/rdata out); cpu_stall; mem_en/mem_we/
//           mem_addr/mem_wdata (registered) and mem_rdata; busy; owner.
// Macro   : MEM_ARB_RR_EN selects round-robin tie breaking (adds 'last' reg);
//           default build uses fixed priority with DBG winning ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // Debug / loader port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  // Memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // Status
  output logic          busy,
  output logic          owner
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             load;        // grant taken this cycle (IDLE -> ACCESS)
  logic             access_done; // last ACCESS cycle, data sampled now

  logic             grant_valid;
  logic             grant_owner;
  logic             last_q;

  logic             owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    rdata_q;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  // ------------------------------------------------------------------
  // Winner select and request mux
  // ------------------------------------------------------------------
  mem_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_owner == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    access_done = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          access_done = 1'b1;
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        // Ack is a single cycle; arbitration resumes in the following IDLE.
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Transaction datapath and registered memory interface
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_CPU;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Write strobe is only ever set by a fresh grant, so a store is
      // issued exactly once regardless of access length.
      mem_we <= 1'b0;
      if (load) begin
        owner_q   <= grant_owner;
        we_q      <= sel_we;
        cnt_q     <= CNT_INIT;
        mem_en    <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end else if (state_q == ARB_ACCESS) begin
        if (access_done) begin
          mem_en <= 1'b0;
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Fairness state: previous winner, only needed for round-robin
  // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset to DBG so the CPU wins the first tie.
      last_q <= OWN_DBG;
    end else if (load) begin
      last_q <= grant_owner;
    end
  end
`else
  assign last_q = OWN_DBG;
`endif

  // ------------------------------------------------------------------
  // Port outputs
  // ------------------------------------------------------------------
  assign busy      = (state_q != ARB_IDLE);
  assign owner     = owner_q;
  assign cpu_ack   = (state_q == ARB_RESP) && (owner_q == OWN_CPU);
  assign dbg_ack   = (state_q == ARB_RESP) && (owner_q == OWN_DBG);
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
